// File: rtl/nr_pkg.sv
// nr_pkg: shared FSM type, internal fixed-point format constants and
// arithmetic helpers for the sequential Newton-Raphson reciprocal unit.
package nr_pkg;

  // Controller states of the reciprocal sequencer.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NORM   = 3'd1,
    SEED   = 3'd2,
    MUL_DY = 3'd3,
    MUL_YE = 3'd4,
    DENORM = 3'd5,
    DONE   = 3'd6
  } nr_state_e;

  // Internal format: unsigned, two integer bits, and four fraction bits
  // more than the operand width so truncation error stays far below the
  // final rounding point.
  localparam int NR_GUARD = 4;
  localparam int NR_IBITS = 2;

  // Rational constant num/den expressed with frac fraction bits, rounded
  // to nearest.
  function automatic longint nr_const(input longint num, input longint den,
                                      input int frac);
    return ((num <<< frac) + (den / 64'sd2)) / den;
  endfunction

  // Scale v by 2^-sh with half-up rounding; a negative sh scales up.
  function automatic logic [63:0] nr_round_shift(input logic [63:0] v,
                                                 input int sh);
    logic [63:0] r;
    if (sh > 0) begin
      r = (v + (64'd1 << (sh - 1))) >> sh;
    end else begin
      r = v << (-sh);
    end
    return r;
  endfunction

endpackage

// File: rtl/nr_lzc.sv
// nr_lzc: combinational leading-one detector. pos is the index of the most
// significant set bit of a; zero flags an all-zero input (pos is then 0).
module nr_lzc #(
  parameter int WIDTH = 18,
  parameter int PW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  output logic [PW-1:0]    pos,
  output logic             zero
);

  // Scan from LSB to MSB so the highest set bit is the last one recorded.
  always_comb begin
    pos = {PW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      pos = a[i] ? PW'(i) : pos;
    end
  end

  assign zero = (a == {WIDTH{1'b0}});

endmodule

// File: rtl/nr_recip_seq.sv
// nr_recip_seq: sequential reciprocal r = 1/d in signed fixed point.
// Normalizes |d| to [0.5,1), seeds with 48/17 - 32/17*M, refines ITER
// times with x = x*(2 - M*x) through one shared multiplier, then
// denormalizes, rounds half-up, clamps and restores the sign.
// Optional build macro NR_RECIP_EARLY_EXIT_EN: power-of-two magnitudes
// load y = 2.0 in SEED and skip the refinement passes.
module nr_recip_seq #(
  parameter int INTEGER   = 10,
  parameter int DECIMAL   = 7,
  parameter int PRECISION = 1 + INTEGER + DECIMAL,
  parameter int ITER      = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [PRECISION-1:0] in_d,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [PRECISION-1:0] out_r,
  output logic                 out_err
);
  import nr_pkg::*;

  localparam int F  = PRECISION + NR_GUARD;
  localparam int W  = F + NR_IBITS;
  localparam int PW = $clog2(PRECISION);
  localparam logic [W-1:0] K1  = W'(nr_const(64'sd48, 64'sd17, F));
  localparam logic [W-1:0] K2  = W'(nr_const(64'sd32, 64'sd17, F));
  localparam logic [W-1:0] TWO = W'(64'd2 << F);
  localparam logic [PRECISION-1:0] MAX_MAG = {1'b0, {(PRECISION-1){1'b1}}};
  localparam logic [2:0] LAST_PASS = 3'(ITER - 1);
`ifdef NR_RECIP_EARLY_EXIT_EN
  localparam logic [PRECISION-1:0] HALF_M = {1'b1, {(PRECISION-1){1'b0}}};
`endif

  nr_state_e state_r, state_s;

  logic [PRECISION-1:0] d_r, m_r, res_r;
  logic                 sign_r, zero_r, in_rdy_r, out_vld_r, out_err_r;
  logic [PW-1:0]        p_r;
  logic [W-1:0]         y_r, e_r;
  logic [2:0]           pass_r;

  logic [PRECISION-1:0] d_nxt_s, m_nxt_s, res_nxt_s;
  logic                 sign_nxt_s, zero_nxt_s, in_rdy_nxt_s, out_vld_nxt_s, err_nxt_s;
  logic [PW-1:0]        p_nxt_s;
  logic [W-1:0]         y_nxt_s, e_nxt_s;
  logic [2:0]           pass_nxt_s;

  logic                 accept_s;
  logic [PRECISION-1:0] abs_s, norm_s, mag_s;
  logic [PW-1:0]        lead_s;
  logic                 lzc_zero_s;
  logic [W-1:0]         mf_s, mul_a_s, mul_b_s, prod_t_s;
  logic [2*W-1:0]       prod_s;
  logic [63:0]          rnd_s;
  int                   sh_s;

  assign accept_s = in_vld && in_rdy_r;

  // Magnitude of the latched operand (the most negative value maps to
  // its correct unsigned magnitude).
  always_comb begin
    abs_s = d_r[PRECISION-1] ? ({PRECISION{1'b0}} - d_r) : d_r;
  end

  nr_lzc #(.WIDTH(PRECISION), .PW(PW)) u_lzc (
    .a    (abs_s),
    .pos  (lead_s),
    .zero (lzc_zero_s)
  );

  // Left-justify the magnitude so its MSB sits at weight 0.5.
  always_comb begin
    norm_s = abs_s << (PW'(PRECISION - 1) - lead_s);
  end

  assign mf_s = {{NR_IBITS{1'b0}}, m_r, {NR_GUARD{1'b0}}};

  // Route the single multiplier's operands according to the current step.
  always_comb begin
    case (state_r)
      SEED:    begin mul_a_s = K2;   mul_b_s = mf_s; end
      MUL_DY:  begin mul_a_s = mf_s; mul_b_s = y_r;  end
      MUL_YE:  begin mul_a_s = y_r;  mul_b_s = e_r;  end
      default: begin mul_a_s = {W{1'b0}}; mul_b_s = {W{1'b0}}; end
    endcase
  end

  assign prod_s   = {{W{1'b0}}, mul_a_s} * {{W{1'b0}}, mul_b_s};
  assign prod_t_s = W'(prod_s >> F);

  // Move y into the DECIMAL-fraction result domain, round and clamp.
  always_comb begin
    sh_s  = F + 1 + int'(p_r) - 2 * DECIMAL;
    rnd_s = nr_round_shift(64'(y_r), sh_s);
    mag_s = (rnd_s > 64'(MAX_MAG)) ? MAX_MAG : rnd_s[PRECISION-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a zero operand still visits DENORM so the result
  // register has a single load point.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:   state_s = accept_s ? NORM : IDLE;
      NORM:   state_s = lzc_zero_s ? DENORM : SEED;
`ifdef NR_RECIP_EARLY_EXIT_EN
      SEED:   state_s = (m_r == HALF_M) ? DENORM : MUL_DY;
`else
      SEED:   state_s = MUL_DY;
`endif
      MUL_DY: state_s = MUL_YE;
      MUL_YE: state_s = (pass_r == LAST_PASS) ? DENORM : MUL_DY;
      DENORM: state_s = DONE;
      DONE:   state_s = out_rdy ? IDLE : DONE;
      default: state_s = IDLE;
    endcase
  end

  // Output and datapath next values for each step.
  always_comb begin
    in_rdy_nxt_s  = (state_s == IDLE);
    out_vld_nxt_s = (state_s == DONE);
    d_nxt_s    = d_r;
    sign_nxt_s = sign_r;
    m_nxt_s    = m_r;
    p_nxt_s    = p_r;
    zero_nxt_s = zero_r;
    y_nxt_s    = y_r;
    e_nxt_s    = e_r;
    pass_nxt_s = pass_r;
    res_nxt_s  = res_r;
    err_nxt_s  = out_err_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          d_nxt_s = in_d;
        end else begin
          d_nxt_s = d_r;
        end
      end
      NORM: begin
        sign_nxt_s = d_r[PRECISION-1];
        m_nxt_s    = norm_s;
        p_nxt_s    = lead_s;
        zero_nxt_s = lzc_zero_s;
        pass_nxt_s = 3'd0;
      end
      SEED: begin
`ifdef NR_RECIP_EARLY_EXIT_EN
        if (m_r == HALF_M) begin
          y_nxt_s = TWO;
        end else begin
          y_nxt_s = K1 - prod_t_s;
        end
`else
        y_nxt_s = K1 - prod_t_s;
`endif
      end
      MUL_DY: e_nxt_s = TWO - prod_t_s;
      MUL_YE: begin
        y_nxt_s    = prod_t_s;
        pass_nxt_s = (pass_r == LAST_PASS) ? 3'd0 : pass_r + 3'd1;
      end
      DENORM: begin
        if (zero_r) begin
          res_nxt_s = MAX_MAG;
          err_nxt_s = 1'b1;
        end else begin
          res_nxt_s = sign_r ? ({PRECISION{1'b0}} - mag_s) : mag_s;
          err_nxt_s = 1'b0;
        end
      end
      default: begin
        res_nxt_s = res_r;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_r       <= {PRECISION{1'b0}};
      sign_r    <= 1'b0;
      m_r       <= {PRECISION{1'b0}};
      p_r       <= {PW{1'b0}};
      zero_r    <= 1'b0;
      y_r       <= {W{1'b0}};
      e_r       <= {W{1'b0}};
      pass_r    <= 3'd0;
      res_r     <= {PRECISION{1'b0}};
      out_err_r <= 1'b0;
      in_rdy_r  <= 1'b0;
      out_vld_r <= 1'b0;
    end else begin
      d_r       <= d_nxt_s;
      sign_r    <= sign_nxt_s;
      m_r       <= m_nxt_s;
      p_r       <= p_nxt_s;
      zero_r    <= zero_nxt_s;
      y_r       <= y_nxt_s;
      e_r       <= e_nxt_s;
      pass_r    <= pass_nxt_s;
      res_r     <= res_nxt_s;
      out_err_r <= err_nxt_s;
      in_rdy_r  <= in_rdy_nxt_s;
      out_vld_r <= out_vld_nxt_s;
    end
  end

  assign in_rdy  = in_rdy_r;
  assign out_vld = out_vld_r;
  assign out_r   = res_r;
  assign out_err = out_err_r;

endmodule

// File: tb/tb_nr_recip_seq.sv
// tb_nr_recip_seq: scoreboard bench for nr_recip_seq. Expected results come
// from an ideal reciprocal (exact rational quotient, half-up rounding,
// saturation) rather than from the Newton-Raphson steps.
module tb_nr_recip_seq;
  localparam int P    = 18;
  localparam int DEC  = 7;
  localparam int ITER = 3;

  logic clk = 1'b0;
  logic rst_n, in_vld, in_rdy, out_vld, out_rdy, out_err;
  logic [P-1:0] in_d, out_r;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;

  typedef struct {
    logic [P-1:0] r;
    logic         err;
    int           acc;
    int           lat;
  } exp_t;
  exp_t exp_q[$];

  nr_recip_seq #(.INTEGER(10), .DECIMAL(DEC), .ITER(ITER)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_d(in_d),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_r(out_r), .out_err(out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Ideal reciprocal of d in the DEC-fraction format.
  function automatic exp_t model(input logic [P-1:0] d);
    exp_t e;
    longint sd, a, q;
    sd = longint'(signed'(d));
    a = (sd < 0) ? -sd : sd;
    e.acc = 0;
    if (a == 0) begin
      e.r = 18'h1FFFF;
      e.err = 1'b1;
      e.lat = 2;
    end else begin
      q = ((longint'(1) << (2 * DEC + 1)) + a) / (2 * a);
      if (q > 131071) q = 131071;
      if (sd < 0) q = -q;
      e.r = P'(q);
      e.err = 1'b0;
      e.lat = 3 + 2 * ITER;
`ifdef NR_RECIP_EARLY_EXIT_EN
      if ((a & (a - 1)) == 0) e.lat = 3;
`endif
    end
    return e;
  endfunction

  task automatic send(input logic [P-1:0] d, input bit push);
    int g = 0;
    exp_t e;
    @(negedge clk);
    while (!in_rdy && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!in_rdy) begin
      chk("in_rdy_timeout", in_rdy, 1);
    end else begin
      in_vld = 1'b1;
      in_d = d;
      @(posedge clk);
      #1;
      if (push) begin
        e = model(d);
        e.acc = cyc;
        exp_q.push_back(e);
      end
      in_vld = 1'b0;
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || out_vld) && g < 400) begin
      @(negedge clk);
      g++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor / consumer: checks every valid cycle, pops on handshake.
  initial begin
    int vcnt = 0;
    out_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        vcnt = 0;
        out_rdy = 1'b0;
      end else if (out_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_vld", out_vld, 0);
          out_rdy = 1'b1;
        end else begin
          if (vcnt == 0) chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
          chk("out_r", out_r, exp_q[0].r);
          chk("out_err", out_err, exp_q[0].err);
          chk("in_rdy_busy", in_rdy, 0);
          case (rdy_mode)
            0:       out_rdy = 1'b1;
            2:       out_rdy = (vcnt >= 5);
            default: out_rdy = 1'($urandom_range(0, 1));
          endcase
          if (out_rdy) begin
            void'(exp_q.pop_front());
            vcnt = 0;
          end else begin
            vcnt++;
          end
        end
      end else begin
        out_rdy = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    int dir_vals[11] = '{128, 384, -512, 1, -131072, 0, 32768, -1, 131071, 3, 256};
    rst_n = 1'b0;
    in_vld = 1'b0;
    in_d = {P{1'b0}};
    repeat (3) @(negedge clk);
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_out_err", out_err, 0);
    rst_n = 1'b1;
    #1;
    chk("in_rdy_before_clk", in_rdy, 0);
    @(negedge clk);
    chk("in_rdy_after_release", in_rdy, 1);

    rdy_mode = 0;
    foreach (dir_vals[i]) send(P'(dir_vals[i]), 1'b1);
    drain();

    rdy_mode = 2;
    send(P'(384), 1'b1);
    drain();

    rdy_mode = 1;
    repeat (40) send(P'($urandom), 1'b1);
    drain();

    rdy_mode = 0;
    repeat (10) send(P'($urandom), 1'b1);
    drain();

    send(P'(384), 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_in_rdy", in_rdy, 0);
    chk("abort_out_vld", out_vld, 0);
    chk("abort_out_r", out_r, 0);
    chk("abort_out_err", out_err, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(P'(256), 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
